// File: rtl/adder_sum_stage_pkg.sv
// rtl/adder_sum_stage_pkg.sv - shared defines, state encoding and result types for the sum stage
`ifndef ADDER_SUM_STAGE_DEFS
`define ADDER_SUM_STAGE_DEFS
`define LEN_DATA     32
`define ASS_STATE_W  2
`define ASS_ST_EMPTY 2'd0
`define ASS_ST_ONE   2'd1
`define ASS_ST_FULL  2'd2
`define ASS_FLAG_W   4
`endif

package adder_sum_stage_pkg;

  localparam int DATA_W = `LEN_DATA;
  localparam int FLAG_W = `ASS_FLAG_W;

  typedef enum logic [`ASS_STATE_W-1:0] {
    ST_EMPTY = `ASS_ST_EMPTY,
    ST_ONE   = `ASS_ST_ONE,
    ST_FULL  = `ASS_ST_FULL
  } state_e;

  localparam int FLAG_CARRY = 3;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_NEG   = 0;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic [FLAG_W-1:0] flags;
  } result_t;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic carry, input logic ovf,
                                                   input logic zero, input logic neg);
    return {carry, ovf, zero, neg};
  endfunction

endpackage

// File: rtl/adder_sum_stage_if.sv
// rtl/adder_sum_stage_if.sv - upstream prefix word and downstream result handshake bundle
interface adder_sum_stage_if;
  import adder_sum_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] group_g;
  logic [DATA_W-1:0] group_p;
  logic [DATA_W-1:0] half_sum;
  logic              carry_in;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] sum;
  logic              carry_out;
  logic              overflow;
  logic              zero;
  logic              negative;

  modport slave (
    input  in_valid, group_g, group_p, half_sum, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, zero, negative
  );

  modport master (
    output in_valid, group_g, group_p, half_sum, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, zero, negative
  );

endinterface

// File: rtl/adder_sum_cell.sv
// rtl/adder_sum_cell.sv - combinational carry resolve, final sum and status flags
module adder_sum_cell
  import adder_sum_stage_pkg::*;
(
  input  logic [DATA_W-1:0] group_g,
  input  logic [DATA_W-1:0] group_p,
  input  logic [DATA_W-1:0] half_sum,
  input  logic              carry_in,
  output logic [DATA_W-1:0] sum,
  output logic              carry_out,
  output logic              overflow,
  output logic              zero,
  output logic              negative
);

  logic [DATA_W:0] carry;

  // Group G/P already span bits [i:0], so every carry is one AND-OR away from carry_in.
  assign carry     = {group_g | (group_p & {DATA_W{carry_in}}), carry_in};
  assign sum       = half_sum ^ carry[DATA_W-1:0];
  assign carry_out = carry[DATA_W];
  assign overflow  = carry[DATA_W] ^ carry[DATA_W-1];
  assign zero      = (sum == '0);
  assign negative  = sum[DATA_W-1];

endmodule

// File: rtl/adder_sum_stage.sv
// rtl/adder_sum_stage.sv - final adder stage with a 2-entry skid buffer on the result
module adder_sum_stage
  import adder_sum_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  adder_sum_stage_if.slave   bus
);

  logic [DATA_W-1:0] cell_sum;
  logic              cell_carry;
  logic              cell_ovf;
  logic              cell_zero;
  logic              cell_neg;
  result_t           cell_res;

  adder_sum_cell u_cell (
    .group_g   (bus.group_g),
    .group_p   (bus.group_p),
    .half_sum  (bus.half_sum),
    .carry_in  (bus.carry_in),
    .sum       (cell_sum),
    .carry_out (cell_carry),
    .overflow  (cell_ovf),
    .zero      (cell_zero),
    .negative  (cell_neg)
  );

  assign cell_res.sum   = cell_sum;
  assign cell_res.flags = pack_flags(cell_carry, cell_ovf, cell_zero, cell_neg);

  state_e  state_q, state_d;
  result_t main_q, main_d;
  result_t skid_q, skid_d;
  logic    out_valid_q, out_valid_d;
  logic    in_ready_q, in_ready_d;
  logic    in_xfer;
  logic    out_xfer;

  // in_ready comes straight from a flop so it never sees out_ready combinationally.
  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = out_valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_d  = cell_res;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = cell_res;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end else if (in_xfer) begin
          skid_d  = cell_res;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = main_q.sum;
  assign bus.carry_out = main_q.flags[FLAG_CARRY];
  assign bus.overflow  = main_q.flags[FLAG_OVF];
  assign bus.zero      = main_q.flags[FLAG_ZERO];
  assign bus.negative  = main_q.flags[FLAG_NEG];

endmodule
